// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: buffers {pc, instr} pairs in a circular
// buffer and hands them to decode in order through a valid/ready handshake.
module if_id_queue #(
   parameter int          DEPTH     = 4,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_pc,
   input  logic [31:0]              in_instr,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_pc,
   output logic [31:0]              out_instr,
   output logic [$clog2(DEPTH):0]   out_count
);

   localparam int          PW         = $clog2(DEPTH);
   localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

   logic [63:0]   entries [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic          push;
   logic          pop;
   logic [63:0]   head;

   assign in_ready  = (count != FULL_COUNT);
   assign out_valid = (count != '0);
   assign out_count = count;

   // Flush wins over both handshakes so a redirect never keeps stale work.
   assign push = in_valid && in_ready && !flush;
   assign pop  = out_valid && out_ready && !flush;

   assign head      = entries[rd_ptr];
   assign out_pc    = out_valid ? head[63:32] : 32'h0;
   assign out_instr = out_valid ? head[31:0]  : NOP_INSTR;

   // Entry storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         entries[wr_ptr] <= {in_pc, in_instr};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios followed by random
// traffic, all compared against an in-order queue model of the buffer.
module tb_if_id_queue;

   localparam int          DEPTH     = 4;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [31:0] in_instr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [2:0]  out_count;

   int vectors;
   int miscompares;

   logic [63:0] model_q [$];

   if_id_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP_INSTR)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pc     (in_pc),
      .in_instr  (in_instr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc    (out_pc),
      .out_instr (out_instr),
      .out_count (out_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected outputs come straight from the model's occupancy and head entry.
   task automatic checkOutput(input string tag);
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic [31:0] exp_instr;
      exp_valid = (model_q.size() != 0);
      exp_pc    = exp_valid ? model_q[0][63:32] : 32'h0;
      exp_instr = exp_valid ? model_q[0][31:0]  : NOP_INSTR;
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
      chk({tag, ".in_ready"},  32'(in_ready),  32'(model_q.size() != DEPTH));
      chk({tag, ".out_count"}, 32'(out_count), 32'(model_q.size()));
      chk({tag, ".out_pc"},    out_pc,    exp_pc);
      chk({tag, ".out_instr"}, out_instr, exp_instr);
   endtask

   task automatic applyStimulus(input string tag, input logic v, input logic r, input logic f,
                                input logic [31:0] pc, input logic [31:0] instr);
      logic do_push;
      logic do_pop;
      in_valid  = v;
      out_ready = r;
      flush     = f;
      in_pc     = pc;
      in_instr  = instr;
      @(posedge clk);
      if (f) begin
         model_q.delete();
      end else begin
         do_push = v && (model_q.size() < DEPTH);
         do_pop  = r && (model_q.size() > 0);
         if (do_pop)  void'(model_q.pop_front());
         if (do_push) model_q.push_back({pc, instr});
      end
      #1;
      checkOutput(tag);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b0;
      flush       = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      in_pc       = '0;
      in_instr    = '0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset");
      @(negedge clk);
      reset = 1'b1;
      $display("[TB] reset released");

      applyStimulus("push0", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0050_0093);
      chk("first_head_pc", out_pc, 32'h0);
      chk("first_head_instr", out_instr, 32'h0050_0093);
      applyStimulus("push1", 1'b1, 1'b0, 1'b0, 32'h4, 32'h00A0_0113);
      applyStimulus("push2", 1'b1, 1'b0, 1'b0, 32'h8, 32'h0020_81B3);
      chk("count3", 32'(out_count), 32'd3);

      applyStimulus("push3_full", 1'b1, 1'b0, 1'b0, 32'hC, 32'h1111_1111);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_count", 32'(out_count), 32'd4);
      applyStimulus("fifth_beat", 1'b1, 1'b0, 1'b0, 32'h10, 32'h2222_2222);
      applyStimulus("pop_when_full", 1'b1, 1'b1, 1'b0, 32'h10, 32'h2222_2222);
      chk("ready_after_full_pop", 32'(in_ready), 32'd1);

      // Drain to three entries, then flush alongside a push that must be dropped.
      applyStimulus("drain", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("pre_flush_count", 32'(out_count), 32'd3);
      applyStimulus("flush", 1'b1, 1'b0, 1'b1, 32'h20, 32'h3333_3333);
      chk("flush_instr", out_instr, NOP_INSTR);
      applyStimulus("post_flush_push", 1'b1, 1'b0, 1'b0, 32'h100, 32'h4444_4444);
      chk("post_flush_head", out_pc, 32'h100);
      applyStimulus("clear", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);

      for (int i = 0; i < 12; i++) begin
         applyStimulus("stream", 1'b1, 1'b1, 1'b0, 32'(i * 4), $urandom);
         chk("stream_pc", out_pc, 32'(i * 4));
      end

      // Reset between edges must clear outputs without waiting for a clock.
      #2;
      reset = 1'b0;
      #1;
      model_q.delete();
      checkOutput("async_reset");
      @(posedge clk);
      #1;
      checkOutput("reset_held");
      @(negedge clk);
      reset    = 1'b1;
      in_valid = 1'b0;
      applyStimulus("push_after_reset", 1'b1, 1'b0, 1'b0, 32'h0, 32'hABCD_0001);
      chk("reset_head_pc", out_pc, 32'h0);
      applyStimulus("clear2", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);

      for (int i = 0; i < 3; i++) begin
         applyStimulus("empty_pop", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      end
      applyStimulus("after_empty_push", 1'b1, 1'b0, 1'b0, 32'h40, 32'h5555_5555);
      applyStimulus("after_empty_pop", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);

      $display("[TB] random traffic");
      for (int i = 0; i < 300; i++) begin
         applyStimulus("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 15) == 0), $urandom, $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
